// File: rtl/weight_ram_loader_if.sv
// Loader bus: streamed write side, status outputs and the registered read port.
// master drives the stream and read requests; slave is the loader itself.
interface weight_ram_loader_if #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 5
);
    logic             start;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             loading;
    logic             load_done;
    logic [ADDR:0]    wr_count;
    logic             rd_en;
    logic [ADDR-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output start, s_valid, s_data, rd_en, rd_addr,
        input  s_ready, loading, load_done, wr_count, rd_data, rd_valid
    );

    modport slave (
        input  start, s_valid, s_data, rd_en, rd_addr,
        output s_ready, loading, load_done, wr_count, rd_data, rd_valid
    );
endinterface

// File: rtl/weight_ram_loader.sv
// Fills a 2**ADDR-word RAM from a valid/ready stream after start, then serves reads.
// Latency: write lands on the transfer edge; read data valid one cycle after rd_en.
// Backpressure: s_ready is high only in LOAD and drops on the edge taking the last word.
module weight_ram_loader #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 5
) (
    input  logic                clk,
    input  logic                rst,
    weight_ram_loader_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state_q,     state_d;
    logic [ADDR-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [ADDR:0]    wr_count_q,  wr_count_d;
    logic             s_ready_q,   s_ready_d;
    logic             loading_q,   loading_d;
    logic             load_done_q, load_done_d;
    logic             rd_valid_q,  rd_valid_d;
    logic [WIDTH-1:0] rd_data_q,   rd_data_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             xfer;

    assign xfer = bus.s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_count_q != (ADDR+1)'(DEPTH)) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                    // The pointer wraps to 0 here, but leaving LOAD keeps it from re-writing word 0.
                    if (wr_ptr_q == ADDR'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d   = (state_d == LOAD);
        loading_d   = (state_d == LOAD);
        load_done_d = (state_d == DONE);

        // Reads qualify on the current load_done, so a read alongside a restart is still served.
        rd_valid_d = bus.rd_en && load_done_q;
        rd_data_d  = rd_valid_d ? mem[bus.rd_addr] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_count_q  <= '0;
            s_ready_q   <= 1'b0;
            loading_q   <= 1'b0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_count_q  <= wr_count_d;
            s_ready_q   <= s_ready_d;
            loading_q   <= loading_d;
            load_done_q <= load_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // RAM contents survive reset so a partial or previous image stays readable later.
    always_ff @(posedge clk) begin
        if (!rst && xfer) begin
            mem[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.loading   = loading_q;
    assign bus.load_done = load_done_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_weight_ram_loader.sv
// Bench for weight_ram_loader: fixed vector table, directed load/readback/abort/reload
// sequences and a randomized tail, all checked against a per-cycle reference model.
module tb_weight_ram_loader;
    localparam int WIDTH = 16;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_ram_loader_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();
    weight_ram_loader #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 loading, 2 full; count doubles as next write address.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_rd_data = 16'h0;
    bit          m_rd_valid = 1'b0;

    typedef struct {
        bit          r, st, sv;
        logic [15:0] sd;
        bit          re;
        int          ra;
        bit          e_rdy, e_ld, e_done;
        int          e_cnt;
        bit          e_rv;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit st, input bit sv, input logic [15:0] sd,
                         input bit re, input int ra);
        rst         = r;
        bus.start   = st;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.rd_en   = re;
        bus.rd_addr = ra[4:0];
        if (r) begin
            m_phase = 0; m_cnt = 0; m_rd_valid = 1'b0; m_rd_data = 16'h0;
        end else begin
            m_rd_valid = re && (m_phase == 2);
            if (m_rd_valid) m_rd_data = m_mem[ra];
            if (m_phase == 1 && sv) begin
                m_mem[m_cnt] = sd;
                m_cnt++;
                if (m_cnt == DEPTH) m_phase = 2;
            end else if (st && m_phase != 1) begin
                m_phase = 1; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        check("s_ready",   bus.s_ready,   m_phase == 1);
        check("loading",   bus.loading,   m_phase == 1);
        check("load_done", bus.load_done, m_phase == 2);
        check("wr_count",  bus.wr_count,  m_cnt);
        check("rd_valid",  bus.rd_valid,  m_rd_valid);
        check("rd_data",   bus.rd_data,   m_rd_data);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 16'h0, 0, 0);
    endtask

    function automatic logic [15:0] word(input int mode, input int k);
        case (mode)
            0:       return 16'h0100 + 16'(k);
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Start a load and stream words until max_words accepted or the RAM fills.
    task automatic load_words(input int mode, input int pct, input int max_words);
        int budget;
        bit sv;
        cycle(0, 1, 0, 16'h0, 0, 0);
        budget = 0;
        while (m_phase == 1 && m_cnt < max_words && budget < 4000) begin
            sv = ($urandom_range(0, 99) < pct);
            cycle(0, 0, sv, sv ? word(mode, m_cnt) : 16'($urandom),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
            budget++;
        end
        check("load_budget", int'(budget < 4000), 1);
    endtask

    task automatic readback();
        int run = 0;
        for (int a = 0; a < DEPTH; a++) begin
            cycle(0, 0, 0, 16'h0, 1, a);
            if (bus.rd_valid) run++;
        end
        check("rd_valid_run", run, DEPTH);
        idle();
    endtask

    initial begin
        rst = 1'b1; bus.start = 0; bus.s_valid = 0; bus.s_data = 0; bus.rd_en = 0; bus.rd_addr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;

        //              r st sv sd        re ra  rdy ld done cnt rv
        tbl[0]  = '{1, 0, 1, 16'h1234, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 16'h1234, 1, 2,  0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 16'h1234, 0, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 16'hAAAA, 0, 0,  0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 16'h0,    1, 3,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 16'h0,    0, 0,  1, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 16'h1111, 0, 0,  1, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 16'h5555, 0, 0,  1, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 16'h2222, 0, 0,  1, 1, 0, 2, 0};
        tbl[9]  = '{0, 0, 0, 16'h0,    1, 0,  1, 1, 0, 2, 0};
        tbl[10] = '{1, 0, 1, 16'h3333, 0, 0,  0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 16'h0,    1, 1,  0, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].st, tbl[i].sv, tbl[i].sd, tbl[i].re, tbl[i].ra);
            check($sformatf("vec%0d_ready", i), bus.s_ready,   tbl[i].e_rdy);
            check($sformatf("vec%0d_load", i),  bus.loading,   tbl[i].e_ld);
            check($sformatf("vec%0d_done", i),  bus.load_done, tbl[i].e_done);
            check($sformatf("vec%0d_count", i), bus.wr_count,  tbl[i].e_cnt);
            check($sformatf("vec%0d_rv", i),    bus.rd_valid,  tbl[i].e_rv);
        end

        // Full load with s_valid held high, then a 33rd word that must be refused.
        load_words(0, 100, DEPTH);
        check("full_count", bus.wr_count, 32);
        check("full_done", bus.load_done, 1);
        check("full_ready", bus.s_ready, 0);
        cycle(0, 0, 1, 16'h0120, 0, 0);
        check("extra_word_count", bus.wr_count, 32);
        readback();
        cycle(0, 0, 0, 16'h0, 1, 0);
        check("word0_kept", bus.rd_data, 16'h0100);

        // Backpressure: same image with ~50% valid gaps.
        load_words(0, 50, DEPTH);
        readback();

        // Abort at word 10, then reload all-ones.
        load_words(0, 100, 10);
        check("abort_count", bus.wr_count, 10);
        cycle(1, 0, 1, 16'h0, 0, 0);
        check("abort_done", bus.load_done, 0);
        cycle(0, 0, 0, 16'h0, 1, 4);
        check("abort_rv", bus.rd_valid, 0);
        load_words(1, 70, DEPTH);
        readback();

        // Reload: start and read together in DONE.
        cycle(0, 1, 0, 16'h0, 1, 5);
        check("reload_rv", bus.rd_valid, 1);
        check("reload_old", bus.rd_data, 16'hFFFF);
        idle();
        check("reload_cleared", bus.load_done, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 16'h0, 1, i);
        load_words(2, 60, DEPTH);
        readback();

        // Random tail.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                  bit'($urandom_range(0, 1)), 16'($urandom),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
